mem_req_sequencer: RTL and testbench

//  Upstream front-end for the 64-entry Memory block. Accepts read/write requests over valid/ready,

---
 rtl/mem_seq_pkg.sv | 22 ++
 rtl/mem_seq_fifo.sv | 58 +++++
 rtl/mem_req_sequencer.sv | 145 ++++++++++++++
 tb/tb_mem_req_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory request sequencer: FSM state encoding,
// the queued request entry, and the Memory interface widths.
package mem_seq_pkg;

    localparam int ADDR_W = 6;
    localparam int DIN_W  = 8;
    localparam int DOUT_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DIN_W-1:0]  wdata;
    } req_entry_t;

endpackage

// File: rtl/mem_seq_fifo.sv
// Synchronous request FIFO for the sequencer. Head entry is visible
// combinationally; full/empty derive only from the registered count so the
// upstream ready never depends on a same-cycle pop.
module mem_seq_fifo
    import mem_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  req_entry_t push_data,
    input  logic       pop,
    output req_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    req_entry_t       store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = store[rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards everything queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: stale slots are never read while empty.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_req_sequencer.sv
// Front-end for the 64-entry Memory: queues read/write requests, issues one
// ren/wen command per slot, and returns read data on a valid/ready channel.
// Optional MEM_SEQ_STATS_EN adds saturating rd_count/wr_count outputs.
module mem_req_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = mem_seq_pkg::ADDR_W,
    parameter int DIN_W      = mem_seq_pkg::DIN_W,
    parameter int DOUT_W     = mem_seq_pkg::DOUT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DIN_W-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DOUT_W-1:0] rsp_rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DIN_W-1:0]  mem_din,
`ifdef MEM_SEQ_STATS_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    input  logic [DOUT_W-1:0] mem_dout
);

    import mem_seq_pkg::*;

    seq_state_t        state;
    seq_state_t        state_n;
    req_entry_t        push_entry;
    req_entry_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              mem_ren_n;
    logic              mem_wen_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DIN_W-1:0]  mem_din_n;
    logic              rsp_valid_n;
    logic [ADDR_W-1:0] rsp_addr_n;
    logic [DOUT_W-1:0] rsp_rdata_n;

    assign req_ready  = rst_n && !fifo_full;
    assign push       = req_valid && req_ready;
    assign push_entry = '{wr: req_wr, addr: req_addr, wdata: req_wdata};

    mem_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and next-output decode; commands only ever leave IDLE, so
    // ren and wen are mutually exclusive and each lasts exactly one cycle.
    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        mem_ren_n   = 1'b0;
        mem_wen_n   = 1'b0;
        mem_addr_n  = mem_addr;
        mem_din_n   = mem_din;
        rsp_valid_n = rsp_valid;
        rsp_addr_n  = rsp_addr;
        rsp_rdata_n = rsp_rdata;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    mem_ren_n  = !head.wr;
                    mem_wen_n  = head.wr;
                    mem_addr_n = head.addr;
                    mem_din_n  = head.wdata;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                state_n = mem_wen ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                rsp_valid_n = 1'b1;
                rsp_addr_n  = mem_addr;
                rsp_rdata_n = mem_dout;
                state_n     = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, Memory command and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_n;
            mem_ren   <= mem_ren_n;
            mem_wen   <= mem_wen_n;
            mem_addr  <= mem_addr_n;
            mem_din   <= mem_din_n;
            rsp_valid <= rsp_valid_n;
            rsp_addr  <= rsp_addr_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

`ifdef MEM_SEQ_STATS_EN
    // Saturating per-command counters, bumped during the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == ISSUE) begin
            if (mem_ren && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (mem_wen && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer with a behavioural 64x6 Memory model.
// Build with +define+MEM_SEQ_STATS_EN to also exercise the counters.
module tb_mem_req_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_addr;
    logic [5:0] rsp_rdata;
    logic       mem_ren;
    logic       mem_wen;
    logic [5:0] mem_addr;
    logic [7:0] mem_din;
    logic [5:0] mem_dout = '0;
`ifdef MEM_SEQ_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    logic [5:0] mdl [64] = '{default: 6'h00};
    int total = 0;
    int bad = 0;
    int wen_pulses = 0;
    int excl_violations = 0;

    mem_req_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_rdata (rsp_rdata),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
`ifdef MEM_SEQ_STATS_EN
        .rd_count  (rd_count),
        .wr_count  (wr_count),
`endif
        .mem_dout  (mem_dout)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Memory model: registered read, stores only the low six data bits
    always @(posedge clk) begin
        if (mem_wen) mdl[mem_addr] <= mem_din[5:0];
        if (mem_ren) mem_dout <= mdl[mem_addr];
    end

    // Count write pulses and any cycle with both commands asserted
    always @(negedge clk) begin
        if (mem_wen === 1'b1) wen_pulses <= wen_pulses + 1;
        if (mem_ren === 1'b1 && mem_wen === 1'b1) excl_violations <= excl_violations + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic wr, input logic [5:0] addr, input logic [7:0] wdata);
        bit ready_seen;
        int guard;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        guard     = 0;
        do begin
            ready_seen = (req_ready === 1'b1);
            tick();
            guard++;
        end while (!ready_seen && guard < 200);
        req_valid = 1'b0;
        total++;
        if (!ready_seen) begin
            bad++;
            $display("[TB] FAIL push_timeout: addr=%0d not accepted, req_ready=%b expected 1", addr, req_ready);
        end
    endtask

    task automatic wait_rsp(output bit seen);
        int guard;
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        seen = (rsp_valid === 1'b1);
    endtask

    task automatic test_reset();
        bit seen;
        bit ren_seen;
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        tick(); tick();
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b expected 0", req_ready); end
        total++;
        if ({rsp_valid, mem_ren, mem_wen} !== 3'b000) begin
            bad++; $display("[TB] FAIL rst_ctrl: valid/ren/wen=%b expected 000", {rsp_valid, mem_ren, mem_wen});
        end
        total++;
        if (mem_addr !== 6'd0 || mem_din !== 8'd0 || rsp_addr !== 6'd0 || rsp_rdata !== 6'd0) begin
            bad++; $display("[TB] FAIL rst_data: maddr=%0d din=%h raddr=%0d rdata=%h expected all 0", mem_addr, mem_din, rsp_addr, rsp_rdata);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready: got %b expected 1", req_ready); end

        // Park a read in HOLD with two more queued, then reset over it
        push_req(1'b0, 6'd9, 8'h00);
        push_req(1'b0, 6'd10, 8'h00);
        push_req(1'b0, 6'd11, 8'h00);
        wait_rsp(seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL hold_entry: rsp_valid=%b expected 1", rsp_valid); end
        rst_n = 1'b0;
        tick();
        total++;
        if ({rsp_valid, mem_ren, mem_wen, req_ready} !== 4'b0000) begin
            bad++; $display("[TB] FAIL midhold_rst: valid/ren/wen/ready=%b expected 0000", {rsp_valid, mem_ren, mem_wen, req_ready});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL midhold_release: req_ready=%b expected 1", req_ready); end
        ren_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_ren === 1'b1 || rsp_valid === 1'b1) ren_seen = 1'b1;
        end
        total++;
        if (ren_seen) begin bad++; $display("[TB] FAIL dropped_queue: ren/valid activity=1 expected 0"); end
    endtask

    task automatic test_write_read();
        int w0;
        rsp_ready = 1'b1;
        w0 = wen_pulses;
        push_req(1'b1, 6'd5, 8'hA7);
        tick();
        total++;
        if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_addr !== 6'd5 || mem_din !== 8'hA7) begin
            bad++; $display("[TB] FAIL wr_issue: wen=%b ren=%b addr=%0d din=%h expected 1 0 5 a7", mem_wen, mem_ren, mem_addr, mem_din);
        end
        tick();
        total++;
        if (mem_wen !== 1'b0) begin bad++; $display("[TB] FAIL wr_pulse_len: wen=%b expected 0", mem_wen); end
        tick();
        total++;
        if (wen_pulses - w0 !== 1) begin bad++; $display("[TB] FAIL wr_pulse_count: got %0d expected 1", wen_pulses - w0); end

        push_req(1'b0, 6'd5, 8'h00);
        tick();
        total++;
        if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 6'd5) begin
            bad++; $display("[TB] FAIL rd_issue: ren=%b wen=%b addr=%0d expected 1 0 5", mem_ren, mem_wen, mem_addr);
        end
        tick();
        total++;
        if (mem_ren !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL rd_capture: ren=%b valid=%b expected 0 0", mem_ren, rsp_valid);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_addr !== 6'd5 || rsp_rdata !== 6'h27) begin
            bad++; $display("[TB] FAIL rd_rsp: valid=%b addr=%0d data=%h expected 1 5 27", rsp_valid, rsp_addr, rsp_rdata);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_accept: valid=%b expected 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int w0;
        logic       b_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [5:0] b_addr [4] = '{6'd10, 6'd11, 6'd10, 6'd11};
        logic [7:0] b_data [4] = '{8'h3C, 8'hC5, 8'h00, 8'h00};
        logic [5:0] e_addr [3] = '{6'd10, 6'd11, 6'd5};
        logic [5:0] e_data [3] = '{6'h3C, 6'h05, 6'h27};

        rsp_ready = 1'b0;
        w0 = wen_pulses;
        push_req(1'b0, 6'd5, 8'h00);
        wait_rsp(seen);
        total++;
        if (!seen || rsp_addr !== 6'd5 || rsp_rdata !== 6'h27) begin
            bad++; $display("[TB] FAIL b2b_block_rsp: valid=%b addr=%0d data=%h expected 1 5 27", rsp_valid, rsp_addr, rsp_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_wr = b_wr[i]; req_addr = b_addr[i]; req_wdata = b_data[i];
            total++;
            if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", i, req_ready); end
            tick();
        end
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 6'd5; req_wdata = 8'h00;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_full_%0d: req_ready=%b expected 0", i, req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        push_req(1'b0, 6'd5, 8'h00);
        for (int i = 0; i < 3; i++) begin
            wait_rsp(seen);
            total++;
            if (!seen || rsp_addr !== e_addr[i] || rsp_rdata !== e_data[i]) begin
                bad++; $display("[TB] FAIL b2b_rsp_%0d: valid=%b addr=%0d data=%h expected 1 %0d %h", i, rsp_valid, rsp_addr, rsp_rdata, e_addr[i], e_data[i]);
            end
            tick();
        end
        total++;
        if (wen_pulses - w0 !== 2) begin bad++; $display("[TB] FAIL b2b_wen_count: got %0d expected 2", wen_pulses - w0); end
    endtask

    task automatic test_stall();
        bit seen;
        rsp_ready = 1'b0;
        push_req(1'b0, 6'd10, 8'h00);
        push_req(1'b0, 6'd11, 8'h00);
        wait_rsp(seen);
        total++;
        if (!seen || rsp_addr !== 6'd10 || rsp_rdata !== 6'h3C) begin
            bad++; $display("[TB] FAIL stall_first: valid=%b addr=%0d data=%h expected 1 10 3c", rsp_valid, rsp_addr, rsp_rdata);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (rsp_valid !== 1'b1 || rsp_addr !== 6'd10 || rsp_rdata !== 6'h3C || mem_ren !== 1'b0) begin
                bad++; $display("[TB] FAIL stall_hold_%0d: valid=%b addr=%0d data=%h ren=%b expected 1 10 3c 0", i, rsp_valid, rsp_addr, rsp_rdata, mem_ren);
            end
        end
        rsp_ready = 1'b1;
        tick();
        wait_rsp(seen);
        total++;
        if (!seen || rsp_addr !== 6'd11 || rsp_rdata !== 6'h05) begin
            bad++; $display("[TB] FAIL stall_second: valid=%b addr=%0d data=%h expected 1 11 05", rsp_valid, rsp_addr, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_wrap();
        bit seen;
        rsp_ready = 1'b1;
        push_req(1'b1, 6'd63, 8'hFF);
        push_req(1'b1, 6'd0, 8'h12);
        push_req(1'b0, 6'd63, 8'h00);
        push_req(1'b0, 6'd0, 8'h00);
        wait_rsp(seen);
        total++;
        if (!seen || rsp_addr !== 6'd63 || rsp_rdata !== 6'h3F) begin
            bad++; $display("[TB] FAIL wrap_63: valid=%b addr=%0d data=%h expected 1 63 3f", rsp_valid, rsp_addr, rsp_rdata);
        end
        tick();
        wait_rsp(seen);
        total++;
        if (!seen || rsp_addr !== 6'd0 || rsp_rdata !== 6'h12) begin
            bad++; $display("[TB] FAIL wrap_0: valid=%b addr=%0d data=%h expected 1 0 12", rsp_valid, rsp_addr, rsp_rdata);
        end
        tick();
        total++;
        if (excl_violations !== 0) begin bad++; $display("[TB] FAIL ren_wen_exclusive: cycles=%0d expected 0", excl_violations); end
    endtask

`ifdef MEM_SEQ_STATS_EN
    task automatic test_stats();
        bit seen;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
            bad++; $display("[TB] FAIL stats_rst: rd=%0d wr=%0d expected 0 0", rd_count, wr_count);
        end
        rsp_ready = 1'b1;
        push_req(1'b1, 6'd1, 8'h01);
        push_req(1'b1, 6'd2, 8'h02);
        push_req(1'b1, 6'd3, 8'h03);
        push_req(1'b0, 6'd1, 8'h00);
        push_req(1'b0, 6'd2, 8'h00);
        for (int i = 0; i < 2; i++) begin
            wait_rsp(seen);
            tick();
        end
        tick();
        total++;
        if (rd_count !== 16'd2 || wr_count !== 16'd3) begin
            bad++; $display("[TB] FAIL stats_count: rd=%0d wr=%0d expected 2 3", rd_count, wr_count);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
            bad++; $display("[TB] FAIL stats_clear: rd=%0d wr=%0d expected 0 0", rd_count, wr_count);
        end
        rst_n = 1'b1;
        tick();
    endtask
`endif

    // Scenario sequence
    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_wrap();
`ifdef MEM_SEQ_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
